// File: rtl/asyncfifo_pkg.sv
// Shared pointer types and Gray/binary conversions for the async FIFO pointer path.
// Conversions work on a fixed 32-bit carrier so any pointer width up to 32 can use them.
package asyncfifo_pkg;

    localparam int PTR_W = 4;
    localparam int FN_W  = 32;

    typedef logic [PTR_W-1:0] ptr_t;

    // Each binary bit is the XOR of all Gray bits at or above it; width masks the carrier.
    function automatic logic [FN_W-1:0] gray2bin(input logic [FN_W-1:0] ptr, input int width);
        logic [FN_W-1:0] bin;
        logic [FN_W-1:0] mask;
        bin = ptr;
        for (int s = 1; s < FN_W; s++) begin
            bin = bin ^ (ptr >> s);
        end
        mask = '1;
        if (width < FN_W) begin
            mask = ~(mask << width);
        end
        return bin & mask;
    endfunction

    function automatic logic [FN_W-1:0] bin2gray(input logic [FN_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser chain with asynchronous active-low reset.
module sync_chain #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] s [STAGES];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < STAGES; i++) begin
                s[i] <= '0;
            end
        end else begin
            s[0] <= din;
            for (int i = 1; i < STAGES; i++) begin
                s[i] <= s[i-1];
            end
        end
    end

    assign dout = s[STAGES-1];

endmodule

// File: rtl/ptr_sync_gray.sv
// Gray pointer CDC synchroniser with registered binary pointer, advance and change pulse.
// Optional sticky step checker is built only when PTR_STEP_CHK_EN is defined.
module ptr_sync_gray
    import asyncfifo_pkg::*;
#(
    parameter int ADDR_SIZE = 3,
    parameter int STAGES    = 2,
    parameter int MAX_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_SIZE:0] ptr_in,
    output logic [ADDR_SIZE:0] ptr_gray_out,
    output logic [ADDR_SIZE:0] ptr_bin_out,
    output logic [ADDR_SIZE:0] ptr_delta,
    output logic               ptr_changed,
    output logic               err_step
);

    localparam int W = ADDR_SIZE + 1;

    if (STAGES < 2 || MAX_STEP < 0) begin : g_param_check
        $error("ptr_sync_gray: STAGES must be >= 2 and MAX_STEP non-negative");
    end

    logic [W-1:0] bin_p0;
    logic [W-1:0] delta_p0;

    sync_chain #(
        .WIDTH  (W),
        .STAGES (STAGES)
    ) u_sync_chain (
        .clk  (clk),
        .rst  (rst),
        .din  (ptr_in),
        .dout (ptr_gray_out)
    );

    // Stage p0: decode of the synchronised pointer and its modular advance.
    assign bin_p0   = W'(gray2bin(FN_W'(ptr_gray_out), W));
    assign delta_p0 = bin_p0 - ptr_bin_out;

    // Stage p1: registered binary pointer, advance and change pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_bin_out <= '0;
            ptr_delta   <= '0;
            ptr_changed <= 1'b0;
        end else begin
            ptr_bin_out <= bin_p0;
            ptr_delta   <= delta_p0;
            ptr_changed <= (bin_p0 != ptr_bin_out);
        end
    end

`ifdef PTR_STEP_CHK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_step <= 1'b0;
        end else if (FN_W'(delta_p0) > $unsigned(MAX_STEP)) begin
            err_step <= 1'b1;
        end
    end
`else
    assign err_step = 1'b0;
`endif

endmodule

// File: tb/tb_ptr_sync_gray.sv
// Self-checking bench for ptr_sync_gray (ADDR_SIZE=3, STAGES=2, MAX_STEP=1).
// Reference: delay-queue of sampled inputs plus searched Gray decode and modular advance.
module tb_ptr_sync_gray;

    localparam int ADDR_SIZE = 3;
    localparam int STAGES    = 2;
    localparam int MAX_STEP  = 1;
    localparam int W         = ADDR_SIZE + 1;
`ifdef PTR_STEP_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] ptr_in = '0;
    logic [W-1:0] ptr_gray_out, ptr_bin_out, ptr_delta;
    logic         ptr_changed, err_step;

    int checks = 0;
    int errors = 0;

    ptr_sync_gray #(
        .ADDR_SIZE (ADDR_SIZE),
        .STAGES    (STAGES),
        .MAX_STEP  (MAX_STEP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ptr_in       (ptr_in),
        .ptr_gray_out (ptr_gray_out),
        .ptr_bin_out  (ptr_bin_out),
        .ptr_delta    (ptr_delta),
        .ptr_changed  (ptr_changed),
        .err_step     (err_step)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Gray code by definition: adjacent counts differ in one bit.
    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Decode by searching for the count whose Gray code matches.
    function automatic logic [W-1:0] from_gray(input logic [W-1:0] g);
        logic [W-1:0] cand;
        for (int b = 0; b < (1 << W); b++) begin
            cand = W'(b);
            if (to_gray(cand) == g) return cand;
        end
        return '0;
    endfunction

    // Reference model: output Gray is the input seen STAGES edges ago.
    logic [W-1:0] hist [$];
    logic [W-1:0] e_gray = '0, e_bin = '0, e_delta = '0;
    logic         e_chg = 1'b0, e_err = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist.delete();
            e_gray  <= '0;
            e_bin   <= '0;
            e_delta <= '0;
            e_chg   <= 1'b0;
            e_err   <= 1'b0;
        end else begin
            hist.push_back(ptr_in);
            e_delta <= from_gray(e_gray) - e_bin;
            e_chg   <= (from_gray(e_gray) != e_bin);
            e_bin   <= from_gray(e_gray);
            if (CHK_EN && (int'(from_gray(e_gray) - e_bin) > MAX_STEP)) e_err <= 1'b1;
            e_gray  <= (hist.size() >= STAGES) ? hist[hist.size()-STAGES] : '0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        ptr_in = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [13:0] got;
        rst = 1'b0;
        ptr_in = 4'b1010;
        repeat (3) @(negedge clk);
        got = {ptr_gray_out, ptr_bin_out, ptr_delta, ptr_changed, err_step};
        checks++;
        if (got !== 14'd0) begin
            errors++;
            $display("FAIL reset_hold: got %h expected %h", got, 14'd0);
        end
        ptr_in = '0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            got = {ptr_gray_out, ptr_bin_out, ptr_delta, ptr_changed, err_step};
            checks++;
            if (got !== 14'd0) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got %h expected %h", i, got, 14'd0);
            end
        end
    endtask

    // Assumes settled at pointer 0; drives 0001 and checks edge-by-edge.
    task automatic test_increment(input string tag);
        ptr_in = 4'b0001;
        @(negedge clk);
        checks++;
        if (ptr_gray_out !== 4'b0000) begin
            errors++;
            $display("FAIL %s_edge1_gray: got %b expected %b", tag, ptr_gray_out, 4'b0000);
        end
        @(negedge clk);
        checks++;
        if ({ptr_gray_out, ptr_bin_out, ptr_changed} !== {4'b0001, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s_edge2: got gray=%b bin=%0d chg=%b expected gray=0001 bin=0 chg=0",
                     tag, ptr_gray_out, ptr_bin_out, ptr_changed);
        end
        @(negedge clk);
        checks++;
        if ({ptr_bin_out, ptr_delta, ptr_changed, err_step} !== {4'd1, 4'd1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL %s_edge3: got bin=%0d delta=%0d chg=%b err=%b expected 1 1 1 0",
                     tag, ptr_bin_out, ptr_delta, ptr_changed, err_step);
        end
        @(negedge clk);
        checks++;
        if ({ptr_bin_out, ptr_delta, ptr_changed} !== {4'd1, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL %s_edge4: got bin=%0d delta=%0d chg=%b expected 1 0 0",
                     tag, ptr_bin_out, ptr_delta, ptr_changed);
        end
    endtask

    task automatic test_wrap();
        for (int k = 2; k < 16; k++) begin
            ptr_in = to_gray(W'(k));
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        checks++;
        if ({ptr_bin_out, ptr_delta, ptr_changed, err_step} !== {4'd15, 4'd0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL wrap_settle: got bin=%0d delta=%0d chg=%b err=%b expected 15 0 0 0",
                     ptr_bin_out, ptr_delta, ptr_changed, err_step);
        end
        ptr_in = 4'b0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({ptr_bin_out, ptr_delta, ptr_changed} !== {4'd0, 4'd1, 1'b1}) begin
            errors++;
            $display("FAIL wrap: got bin=%0d delta=%0d chg=%b expected 0 1 1",
                     ptr_bin_out, ptr_delta, ptr_changed);
        end
    endtask

    task automatic test_jump();
        do_reset();
        ptr_in = 4'b0001;
        @(negedge clk);
        ptr_in = 4'b0011;
        repeat (4) @(negedge clk);
        checks++;
        if ({ptr_bin_out, err_step} !== {4'd2, 1'b0}) begin
            errors++;
            $display("FAIL jump_pre: got bin=%0d err=%b expected 2 0", ptr_bin_out, err_step);
        end
        ptr_in = 4'b0111;
        repeat (3) @(negedge clk);
        checks++;
        if ({ptr_bin_out, ptr_delta, ptr_changed, err_step} !== {4'd5, 4'd3, 1'b1, CHK_EN}) begin
            errors++;
            $display("FAIL jump: got bin=%0d delta=%0d chg=%b err=%b expected 5 3 1 %b",
                     ptr_bin_out, ptr_delta, ptr_changed, err_step, CHK_EN);
        end
        ptr_in = 4'b0101;
        repeat (3) @(negedge clk);
        checks++;
        if ({ptr_bin_out, ptr_delta, err_step} !== {4'd6, 4'd1, CHK_EN}) begin
            errors++;
            $display("FAIL jump_sticky: got bin=%0d delta=%0d err=%b expected 6 1 %b",
                     ptr_bin_out, ptr_delta, err_step, CHK_EN);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (err_step !== CHK_EN) begin
            errors++;
            $display("FAIL jump_sticky_late: got err=%b expected %b", err_step, CHK_EN);
        end
    endtask

    task automatic test_async_reset();
        logic [13:0] got;
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        got = {ptr_gray_out, ptr_bin_out, ptr_delta, ptr_changed, err_step};
        checks++;
        if (got !== 14'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected %h", got, 14'd0);
        end
        @(negedge clk);
        ptr_in = '0;
        rst = 1'b1;
        @(negedge clk);
        test_increment("after_reset");
    endtask

    task automatic test_random();
        logic [W-1:0] cur;
        logic [13:0]  got, exp;
        do_reset();
        cur = '0;
        for (int n = 0; n < 300; n++) begin
            cur = cur + W'($urandom_range(0, 3));
            ptr_in = to_gray(cur);
            repeat ($urandom_range(1, 3)) begin
                @(negedge clk);
                got = {ptr_gray_out, ptr_bin_out, ptr_delta, ptr_changed, err_step};
                exp = {e_gray, e_bin, e_delta, e_chg, e_err};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL random n=%0d: got %h expected %h", n, got, exp);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_increment("increment");
        test_wrap();
        test_jump();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
